// File: rtl/reg_wb_arbiter_pkg.sv
// Shared definitions for the register write-back arbiter.
// Register-file write-port constants, load sizes and grant encoding.
package reg_wb_arbiter_pkg;

    localparam logic        WriteEnable  = 1'b1;
    localparam logic        WriteDisable = 1'b0;
    localparam logic        RstEnable    = 1'b0;
    localparam logic [31:0] ZeroWord     = 32'h0000_0000;

    localparam logic [1:0] LD_BYTE = 2'd0;
    localparam logic [1:0] LD_HALF = 2'd1;
    localparam logic [1:0] LD_WORD = 2'd2;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_LD,
        GNT_MD,
        GNT_ALU
    } gnt_e;

endpackage

// File: rtl/reg_wb_arbiter_if.sv
// Producer requests, reservation input and register-file write port.
// master = producers/issue side, slave = the arbiter.
interface reg_wb_arbiter_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    logic          alu_valid;
    logic [AW-1:0] alu_addr;
    logic [DW-1:0] alu_data;
    logic          alu_ready;

    logic          ld_valid;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_rdata;
    logic [1:0]    ld_size;
    logic          ld_signed;
    logic [1:0]    ld_offset;
    logic          ld_ready;

    logic          md_valid;
    logic [AW-1:0] md_addr;
    logic [DW-1:0] md_data;
    logic          md_ready;

    logic          rsv_en;
    logic [AW-1:0] rsv_addr;

    logic          wreg;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic [31:0]   busy_mask;
    logic          ld_err;

    modport master (
        output alu_valid, alu_addr, alu_data,
        input  alu_ready,
        output ld_valid, ld_addr, ld_rdata,
        output ld_size, ld_signed, ld_offset,
        input  ld_ready,
        output md_valid, md_addr, md_data,
        input  md_ready,
        output rsv_en, rsv_addr,
        input  wreg, waddr, wdata, busy_mask, ld_err
    );

    modport slave (
        input  alu_valid, alu_addr, alu_data,
        output alu_ready,
        input  ld_valid, ld_addr, ld_rdata,
        input  ld_size, ld_signed, ld_offset,
        output ld_ready,
        input  md_valid, md_addr, md_data,
        output md_ready,
        input  rsv_en, rsv_addr,
        output wreg, waddr, wdata, busy_mask, ld_err
    );

endinterface

// File: rtl/reg_wb_arbiter_load_align.sv
// Load data formatter: lane select, zero/sign extension, alignment check.
// Size 3 is handled as a word access.
module load_align
    import reg_wb_arbiter_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  size,
    input  logic        sgn,
    input  logic [1:0]  offset,
    output logic [31:0] data,
    output logic        misaligned
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b          = rdata[{offset, 3'b000} +: 8];
        h          = offset[1] ? rdata[31:16] : rdata[15:0];
        data       = rdata;
        misaligned = 1'b0;
        case (size)
            LD_BYTE: data = {{24{sgn & b[7]}}, b};
            LD_HALF: begin
                data       = {{16{sgn & h[15]}}, h};
                misaligned = offset[0];
            end
            default: misaligned = (offset != 2'd0);
        endcase
    end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Register-file write-back arbiter: ld > md > alu with ALU anti-starvation,
// one registered commit per cycle and a pending-write scoreboard.
module reg_wb_arbiter
    import reg_wb_arbiter_pkg::*;
#(
    parameter int STARVE_LIM = 4,
    parameter int DW         = 32,
    parameter int AW         = 5
) (
    input logic             clk,
    input logic             resetn,
    reg_wb_arbiter_if.slave bus
);

    localparam int CW = $clog2(STARVE_LIM + 1);

    logic [CW-1:0] starve_cnt;
    gnt_e          gnt;
    logic          starved;

    logic [31:0]   ld_fmt;
    logic          ld_mis;

    logic [AW-1:0] g_addr;
    logic [DW-1:0] g_data;
    logic          g_we;
    logic          g_err;
    logic [31:0]   busy_nxt;

    load_align u_align (
        .rdata     (bus.ld_rdata[31:0]),
        .size      (bus.ld_size),
        .sgn       (bus.ld_signed),
        .offset    (bus.ld_offset),
        .data      (ld_fmt),
        .misaligned(ld_mis)
    );

    assign starved = (starve_cnt == CW'(STARVE_LIM)) && bus.alu_valid;

    always_comb begin
        gnt = GNT_NONE;
        if (resetn != RstEnable) begin
            if (starved)            gnt = GNT_ALU;
            else if (bus.ld_valid)  gnt = GNT_LD;
            else if (bus.md_valid)  gnt = GNT_MD;
            else if (bus.alu_valid) gnt = GNT_ALU;
        end
    end

    assign bus.ld_ready  = (gnt == GNT_LD);
    assign bus.md_ready  = (gnt == GNT_MD);
    assign bus.alu_ready = (gnt == GNT_ALU);

    always_comb begin
        g_addr = '0;
        g_data = '0;
        g_we   = WriteDisable;
        g_err  = 1'b0;
        unique case (gnt)
            GNT_LD: begin
                g_addr = bus.ld_addr;
                g_data = DW'(ld_fmt);
                g_we   = !ld_mis;
                g_err  = ld_mis;
            end
            GNT_MD: begin
                g_addr = bus.md_addr;
                g_data = bus.md_data;
                g_we   = WriteEnable;
            end
            GNT_ALU: begin
                g_addr = bus.alu_addr;
                g_data = bus.alu_data;
                g_we   = WriteEnable;
            end
            default: ;
        endcase
        // r0 is accepted and retired silently
        if (g_addr == '0) g_we = WriteDisable;
    end

    // Reservation applied after the clear so a same-cycle re-issue stays pending
    always_comb begin
        busy_nxt = bus.busy_mask;
        if (gnt != GNT_NONE) busy_nxt[g_addr] = 1'b0;
        if (bus.rsv_en)      busy_nxt[bus.rsv_addr] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (resetn == RstEnable) begin
            starve_cnt <= '0;
        end else if (bus.alu_valid && !bus.alu_ready) begin
            if (starve_cnt != CW'(STARVE_LIM))
                starve_cnt <= starve_cnt + 1'b1;
        end else begin
            starve_cnt <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (resetn == RstEnable) begin
            bus.wreg      <= WriteDisable;
            bus.waddr     <= '0;
            bus.wdata     <= DW'(ZeroWord);
            bus.busy_mask <= '0;
            bus.ld_err    <= 1'b0;
        end else begin
            bus.wreg      <= g_we;
            bus.ld_err    <= g_err;
            bus.busy_mask <= busy_nxt;
            if (gnt != GNT_NONE) begin
                bus.waddr <= g_addr;
                bus.wdata <= g_data;
            end
        end
    end

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed self-checking bench for reg_wb_arbiter.
// Inputs change on negedge; outputs sampled before/after posedge.
module tb_reg_wb_arbiter;

    logic clk;
    logic resetn;
    int   checks;
    int   errors;

    reg_wb_arbiter_if #(.DW(32), .AW(5)) bus ();

    reg_wb_arbiter #(
        .STARVE_LIM(4),
        .DW        (32),
        .AW        (5)
    ) dut (
        .clk   (clk),
        .resetn(resetn),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        bus.alu_valid = 0; bus.alu_addr = 0; bus.alu_data = 0;
        bus.ld_valid  = 0; bus.ld_addr  = 0; bus.ld_rdata = 0;
        bus.ld_size   = 2'd2; bus.ld_signed = 0; bus.ld_offset = 0;
        bus.md_valid  = 0; bus.md_addr  = 0; bus.md_data  = 0;
        bus.rsv_en    = 0; bus.rsv_addr = 0;
    endtask

    task automatic test_reset();
        idle();
        resetn = 0;
        bus.alu_valid = 1; bus.ld_valid = 1; bus.md_valid = 1;
        @(negedge clk); #1;
        checks++;
        if ({bus.ld_ready, bus.md_ready, bus.alu_ready} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ready: got %b want 000",
                     {bus.ld_ready, bus.md_ready, bus.alu_ready});
        end
        @(posedge clk); #1;
        checks++;
        if (bus.wreg !== 1'b0 || bus.wdata !== 32'h0 || bus.waddr !== 5'd0) begin
            errors++;
            $display("FAIL reset_regs: wreg=%b waddr=%0d wdata=%h want 0",
                     bus.wreg, bus.waddr, bus.wdata);
        end
        @(negedge clk);
        resetn = 1;
        idle();
        @(posedge clk); #1;
        checks++;
        if (bus.busy_mask !== 32'h0 || bus.wreg !== 1'b0 || bus.ld_err !== 1'b0) begin
            errors++;
            $display("FAIL after_reset: busy=%h wreg=%b ld_err=%b want 0",
                     bus.busy_mask, bus.wreg, bus.ld_err);
        end
    endtask

    task automatic test_load_lanes();
        logic [1:0]  sz  [6] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd1};
        logic        sg  [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [1:0]  off [6] = '{2'd1, 2'd3, 2'd2, 2'd1, 2'd0, 2'd0};
        logic [31:0] exp [6] = '{32'hFFFFFFAA, 32'h00000088, 32'hFFFF8899,
                                 32'h0, 32'h8899AABB, 32'h0000AABB};
        logic        err [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            idle();
            bus.ld_valid  = 1;
            bus.ld_addr   = 5'd5;
            bus.ld_rdata  = 32'h8899AABB;
            bus.ld_size   = sz[i];
            bus.ld_signed = sg[i];
            bus.ld_offset = off[i];
            #1;
            checks++;
            if (bus.ld_ready !== 1'b1) begin
                errors++;
                $display("FAIL load%0d_ready: got %b want 1", i, bus.ld_ready);
            end
            @(posedge clk); #1;
            checks++;
            if (bus.wreg !== !err[i] || bus.ld_err !== err[i]) begin
                errors++;
                $display("FAIL load%0d_we: wreg=%b ld_err=%b want %b/%b",
                         i, bus.wreg, bus.ld_err, !err[i], err[i]);
            end
            if (!err[i]) begin
                checks++;
                if (bus.wdata !== exp[i] || bus.waddr !== 5'd5) begin
                    errors++;
                    $display("FAIL load%0d_data: got %h@%0d want %h@5",
                             i, bus.wdata, bus.waddr, exp[i]);
                end
            end
        end
        @(negedge clk);
        idle();
        @(posedge clk); #1;
        checks++;
        if (bus.ld_err !== 1'b0 || bus.wreg !== 1'b0) begin
            errors++;
            $display("FAIL load_idle: ld_err=%b wreg=%b want 0/0",
                     bus.ld_err, bus.wreg);
        end
    endtask

    task automatic test_priority();
        @(negedge clk);
        idle();
        bus.ld_valid  = 1; bus.ld_addr  = 5'd1; bus.ld_rdata = 32'h11111111;
        bus.md_valid  = 1; bus.md_addr  = 5'd2; bus.md_data  = 32'h22222222;
        bus.alu_valid = 1; bus.alu_addr = 5'd3; bus.alu_data = 32'h33333333;
        #1;
        checks++;
        if ({bus.ld_ready, bus.md_ready, bus.alu_ready} !== 3'b100) begin
            errors++;
            $display("FAIL prio_c0: got %b want 100",
                     {bus.ld_ready, bus.md_ready, bus.alu_ready});
        end
        @(posedge clk); #1;
        checks++;
        if (bus.wreg !== 1 || bus.waddr !== 5'd1 || bus.wdata !== 32'h11111111) begin
            errors++;
            $display("FAIL prio_w0: got %b %0d %h want 1 1 11111111",
                     bus.wreg, bus.waddr, bus.wdata);
        end
        @(negedge clk);
        bus.ld_valid = 0;
        #1;
        checks++;
        if ({bus.ld_ready, bus.md_ready, bus.alu_ready} !== 3'b010) begin
            errors++;
            $display("FAIL prio_c1: got %b want 010",
                     {bus.ld_ready, bus.md_ready, bus.alu_ready});
        end
        @(posedge clk); #1;
        checks++;
        if (bus.wreg !== 1 || bus.waddr !== 5'd2 || bus.wdata !== 32'h22222222) begin
            errors++;
            $display("FAIL prio_w1: got %b %0d %h want 1 2 22222222",
                     bus.wreg, bus.waddr, bus.wdata);
        end
        @(negedge clk);
        bus.md_valid = 0;
        #1;
        checks++;
        if ({bus.ld_ready, bus.md_ready, bus.alu_ready} !== 3'b001) begin
            errors++;
            $display("FAIL prio_c2: got %b want 001",
                     {bus.ld_ready, bus.md_ready, bus.alu_ready});
        end
        @(posedge clk); #1;
        checks++;
        if (bus.wreg !== 1 || bus.waddr !== 5'd3 || bus.wdata !== 32'h33333333) begin
            errors++;
            $display("FAIL prio_w2: got %b %0d %h want 1 3 33333333",
                     bus.wreg, bus.waddr, bus.wdata);
        end
        @(negedge clk);
        idle();
        @(posedge clk); #1;
        checks++;
        if (bus.wreg !== 0 || bus.waddr !== 5'd3 || bus.wdata !== 32'h33333333) begin
            errors++;
            $display("FAIL prio_hold: got %b %0d %h want 0 3 33333333",
                     bus.wreg, bus.waddr, bus.wdata);
        end
    endtask

    task automatic test_starvation();
        @(negedge clk);
        idle();
        bus.ld_valid  = 1; bus.ld_addr  = 5'd4; bus.ld_rdata = 32'h44444444;
        bus.md_valid  = 1; bus.md_addr  = 5'd6; bus.md_data  = 32'h66666666;
        bus.alu_valid = 1; bus.alu_addr = 5'd9; bus.alu_data = 32'h99999999;
        for (int c = 0; c < 6; c++) begin
            #1;
            checks++;
            if (bus.alu_ready !== (c == 4) || bus.ld_ready !== (c != 4)
                || bus.md_ready !== 1'b0) begin
                errors++;
                $display("FAIL starve_c%0d: ld/md/alu=%b%b%b want %b0%b", c,
                         bus.ld_ready, bus.md_ready, bus.alu_ready,
                         (c != 4), (c == 4));
            end
            @(posedge clk); #1;
            if (c == 4) begin
                checks++;
                if (bus.waddr !== 5'd9 || bus.wdata !== 32'h99999999) begin
                    errors++;
                    $display("FAIL starve_commit: got %0d %h want 9 99999999",
                             bus.waddr, bus.wdata);
                end
            end
            @(negedge clk);
        end
        idle();
    endtask

    task automatic test_scoreboard();
        @(negedge clk);
        idle();
        bus.rsv_en = 1; bus.rsv_addr = 5'd7;
        @(posedge clk); #1;
        checks++;
        if (bus.busy_mask !== 32'h80) begin
            errors++;
            $display("FAIL sb_set: got %h want 00000080", bus.busy_mask);
        end
        @(negedge clk);
        bus.alu_valid = 1; bus.alu_addr = 5'd7; bus.alu_data = 32'h77;
        #1;
        checks++;
        if (bus.alu_ready !== 1'b1) begin
            errors++;
            $display("FAIL sb_ready: got %b want 1", bus.alu_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.busy_mask !== 32'h80 || bus.wreg !== 1 || bus.waddr !== 5'd7) begin
            errors++;
            $display("FAIL sb_setwins: busy=%h wreg=%b waddr=%0d want 80 1 7",
                     bus.busy_mask, bus.wreg, bus.waddr);
        end
        @(negedge clk);
        bus.rsv_en = 0; bus.alu_data = 32'h78;
        @(posedge clk); #1;
        checks++;
        if (bus.busy_mask !== 32'h0 || bus.wdata !== 32'h78) begin
            errors++;
            $display("FAIL sb_clear: busy=%h wdata=%h want 0 78",
                     bus.busy_mask, bus.wdata);
        end
        @(negedge clk);
        idle();
        bus.rsv_en = 1; bus.rsv_addr = 5'd0;
        @(posedge clk); #1;
        checks++;
        if (bus.busy_mask !== 32'h0) begin
            errors++;
            $display("FAIL sb_r0: got %h want 0", bus.busy_mask);
        end
    endtask

    task automatic test_r0();
        @(negedge clk);
        idle();
        bus.rsv_en = 1; bus.rsv_addr = 5'd3;
        @(negedge clk);
        idle();
        bus.alu_valid = 1; bus.alu_addr = 5'd0; bus.alu_data = 32'h1234;
        #1;
        checks++;
        if (bus.alu_ready !== 1'b1) begin
            errors++;
            $display("FAIL r0_ready: got %b want 1", bus.alu_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.wreg !== 1'b0 || bus.busy_mask !== 32'h8 || bus.ld_err !== 1'b0) begin
            errors++;
            $display("FAIL r0_commit: wreg=%b busy=%h ld_err=%b want 0 8 0",
                     bus.wreg, bus.busy_mask, bus.ld_err);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        idle();
        resetn = 0;
        bus.alu_valid = 1; bus.alu_addr = 5'd9; bus.alu_data = 32'hABCD;
        #1;
        checks++;
        if (bus.alu_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_ready: got %b want 0", bus.alu_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.wreg !== 1'b0 || bus.busy_mask !== 32'h0 || bus.waddr !== 5'd0) begin
            errors++;
            $display("FAIL mid_regs: wreg=%b busy=%h waddr=%0d want 0 0 0",
                     bus.wreg, bus.busy_mask, bus.waddr);
        end
        @(negedge clk);
        resetn = 1;
        #1;
        checks++;
        if (bus.alu_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_represent: got %b want 1", bus.alu_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.wreg !== 1'b1 || bus.waddr !== 5'd9 || bus.wdata !== 32'hABCD) begin
            errors++;
            $display("FAIL mid_commit: got %b %0d %h want 1 9 0000abcd",
                     bus.wreg, bus.waddr, bus.wdata);
        end
        @(negedge clk);
        idle();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_load_lanes();
        test_priority();
        test_starvation();
        test_scoreboard();
        test_r0();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
